// File: rtl/jk_flip_flop_bank.sv
`timescale 1ps/1ps
// Bank of WIDTH independent edge-triggered JK flip-flops with per-bit enable,
// synchronous reset to a parameterised value, and a complementary qbar output.

module jk_flip_flop_bank_lane #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);
  logic r_q;

  // Reset wins over enable and over a pending toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (en) begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;
endmodule

module jk_flip_flop_bank #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  logic [WIDTH-1:0] w_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    jk_flip_flop_bank_lane #(
      .RST_VAL (RESET_VALUE[gi])
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en[gi]),
      .j   (j[gi]),
      .k   (k[gi]),
      .q   (w_q[gi])
    );
  end

  assign q    = w_q;
  assign qbar = ~w_q;
endmodule

// File: tb/tb_jk_flip_flop_bank.sv
`timescale 1ps/1ps
// Bench for jk_flip_flop_bank: a characteristic-equation model checked every
// cycle against three instances, plus hand-computed directed expectations.
module tb_jk_flip_flop_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic       en1, j1, k1;
  logic [3:0] en4, j4, k4;
  logic       q0, qb0, q1, qb1;
  logic [3:0] q4, qb4;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  jk_flip_flop_bank #(.WIDTH(1), .RESET_VALUE(1'b0)) d0 (
    .clk(clk), .rst(rst), .en(en1), .j(j1), .k(k1), .q(q0), .qbar(qb0));
  jk_flip_flop_bank #(.WIDTH(1), .RESET_VALUE(1'b1)) d1 (
    .clk(clk), .rst(rst), .en(en1), .j(j1), .k(k1), .q(q1), .qbar(qb1));
  jk_flip_flop_bank #(.WIDTH(4), .RESET_VALUE(4'b0000)) d4 (
    .clk(clk), .rst(rst), .en(en4), .j(j4), .k(k4), .q(q4), .qbar(qb4));

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Characteristic equation Q+ = J.~Q | ~K.Q, gated by enable.
  function automatic logic [3:0] jk_next(input logic [3:0] q, en, j, k);
    return (en & ((j & ~q) | (~k & q))) | (~en & q);
  endfunction

  logic       valid = 1'b0;
  logic       m0, m1;
  logic [3:0] m4;

  always @(posedge clk) begin
    if (rst) begin
      m0 = 1'b0; m1 = 1'b1; m4 = 4'b0000; valid = 1'b1;
    end else begin
      m0 = jk_next({3'b0, m0}, {3'b0, en1}, {3'b0, j1}, {3'b0, k1}) != 4'b0;
      m1 = jk_next({3'b0, m1}, {3'b0, en1}, {3'b0, j1}, {3'b0, k1}) != 4'b0;
      m4 = jk_next(m4, en4, j4, k4);
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("cyc_q0",   {3'b0, q0},  {3'b0, m0});
      chk("cyc_qb0",  {3'b0, qb0}, {3'b0, ~m0});
      chk("cyc_q1",   {3'b0, q1},  {3'b0, m1});
      chk("cyc_qb1",  {3'b0, qb1}, {3'b0, ~m1});
      chk("cyc_q4",   q4,  m4);
      chk("cyc_qb4",  qb4, ~m4);
    end
  end

  // Late in each period q must still hold the value set at the last edge.
  always @(posedge clk) begin
    #17;
    if (valid) begin
      chk("late_q0", {3'b0, q0}, {3'b0, m0});
      chk("late_q1", {3'b0, q1}, {3'b0, m1});
      chk("late_q4", q4, m4);
    end
  end

  // Drive values right after a negedge, let one rising edge pass, then settle.
  task automatic step1(input logic r, input logic e, input logic jj, input logic kk);
    rst = r; en1 = e; j1 = jj; k1 = kk;
    @(negedge clk); #1;
  endtask

  logic exp_tt [7];
  logic [1:0] jk_seq [7];

  initial begin
    rst = 1'b1; en1 = 1'b1; j1 = 1'b1; k1 = 1'b1;
    en4 = 4'b1111; j4 = 4'b1111; k4 = 4'b1111;
    @(negedge clk); #1;
    // Reset with j=k=1 and en=1 must still load RESET_VALUE.
    chk("rst_q0",  {3'b0, q0},  4'd0);
    chk("rst_qb0", {3'b0, qb0}, 4'd1);
    chk("rst_q1",  {3'b0, q1},  4'd1);
    chk("rst_qb1", {3'b0, qb1}, 4'd0);
    chk("rst_q4",  q4, 4'b0000);

    // Truth table walk: 10,00,01,00,11,11,11 -> 1,1,0,0,1,0,1 (both reset values).
    en4 = 4'b0000;
    jk_seq  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};
    exp_tt  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      step1(1'b0, 1'b1, jk_seq[i][1], jk_seq[i][0]);
      chk($sformatf("tt_q0_%0d", i),  {3'b0, q0},  {3'b0, exp_tt[i]});
      chk($sformatf("tt_qb0_%0d", i), {3'b0, qb0}, {3'b0, ~exp_tt[i]});
      chk($sformatf("tt_q1_%0d", i),  {3'b0, q1},  {3'b0, exp_tt[i]});
    end

    // Enable gating on the 4-bit bank.
    en4 = 4'b0101; j4 = 4'b1111; k4 = 4'b0000;
    step1(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gate_set", q4, 4'b0101);
    en4 = 4'b1111; j4 = 4'b1111; k4 = 4'b1111;
    step1(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gate_tog", q4, 4'b1010);
    chk("gate_tog_qb", qb4, 4'b0101);

    // Reset priority mid-toggle, then resume from RESET_VALUE.
    step1(1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b1, 1'b1, 1'b1);
    chk("tog_a", {3'b0, q0}, 4'd1);
    step1(1'b0, 1'b1, 1'b1, 1'b1);
    chk("tog_b", {3'b0, q0}, 4'd0);
    step1(1'b0, 1'b1, 1'b1, 1'b1);
    chk("tog_c", {3'b0, q0}, 4'd1);
    step1(1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_q0", {3'b0, q0}, 4'd0);
    chk("midrst_q1", {3'b0, q1}, 4'd1);
    chk("midrst_q4", q4, 4'b0000);
    step1(1'b0, 1'b1, 1'b1, 1'b1);
    chk("resume_q0", {3'b0, q0}, 4'd1);
    chk("resume_q1", {3'b0, q1}, 4'd0);

    // Glitch immunity: pulses between edges, only the final values count.
    step1(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0; en1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    #2 j1 = 1'b1; #2 j1 = 1'b0; #2 k1 = 1'b1; #1 k1 = 1'b0;
    @(negedge clk); #1;
    chk("glitch_hold_q0", {3'b0, q0}, 4'd0);
    chk("glitch_hold_q1", {3'b0, q1}, 4'd1);
    j1 = 1'b0; k1 = 1'b1;
    #2 k1 = 1'b0; #2 j1 = 1'b1;
    @(negedge clk); #1;
    chk("glitch_set_q0", {3'b0, q0}, 4'd1);
    chk("glitch_set_q1", {3'b0, q1}, 4'd1);
    en1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
    #2 en1 = 1'b1; #2 en1 = 1'b0;
    @(negedge clk); #1;
    chk("glitch_en_q0", {3'b0, q0}, 4'd1);
    chk("glitch_en_q1", {3'b0, q1}, 4'd1);

    // Free-running stimulus: j every 10 ps, k every 15 ps, never on a rising edge.
    rst = 1'b1; en1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    @(negedge clk);
    rst = 1'b0; en4 = 4'b1011; j4 = 4'b0000; k4 = 4'b0101;
    fork
      begin
        #5;
        repeat (50) begin j1 = ~j1; j4 = {4{j1}}; #10; end
      end
      begin
        #2;
        repeat (34) begin k1 = ~k1; k4 = {k1, ~k1, k1, ~k1}; #15; end
      end
    join
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
